// File: rtl/ide_pio_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ide_pio_sequencer
// Description : Turns decoded 68000 IDE accesses into PIO strobe timing.
//               It handles setup, strobe, IORDY wait, hold and recovery, and
//               returns DTACK_n or BERR_n to the CPU.
// Revision    : 1.0 - initial release
// ============================================================================
module ide_pio_sequencer #(
    parameter int T_SETUP       = 2,
    parameter int T_PULSE       = 6,
    parameter int T_HOLD        = 1,
    parameter int T_RECOVER     = 2,
    parameter int IORDY_TIMEOUT = 255,
    parameter int CNT_W         = 8
) (
    input  logic CPUCLK,
    input  logic RESET,
    input  logic IDECS_n,
    input  logic AS_n,
    input  logic UDS_n,
    input  logic RW,
    input  logic IORDY,
    output logic IDERD_n,
    output logic IDEWR_n,
    output logic IDEBUF_n,
    output logic DTACK_n,
    output logic DTACK_OE,
    output logic BERR_n,
    output logic BUSY
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_setup   = 3'd1;
    localparam logic [2:0] c_st_strobe  = 3'd2;
    localparam logic [2:0] c_st_waitrdy = 3'd3;
    localparam logic [2:0] c_st_hold    = 3'd4;
    localparam logic [2:0] c_st_ack     = 3'd5;
    localparam logic [2:0] c_st_err     = 3'd6;
    localparam logic [2:0] c_st_recover = 3'd7;

    localparam logic [CNT_W-1:0] c_setup_ld   = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] c_pulse_ld   = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] c_hold_ld    = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] c_recover_ld = CNT_W'(T_RECOVER - 1);
    localparam logic [CNT_W-1:0] c_to_last    = CNT_W'(IORDY_TIMEOUT - 1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_to_cnt;
    logic             r_rw_q;
    logic             r_as_seen_high;
    logic             r_iordy_m;
    logic             r_iordy_s;

    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_to_nxt;
    logic             w_rw_nxt;
    logic             w_seen_nxt;

    logic             w_iderd_n;
    logic             w_idewr_n;
    logic             w_idebuf_n;
    logic             w_dtack_n;
    logic             w_dtack_oe;
    logic             w_berr_n;
    logic             w_busy;

    // State, counters, IORDY synchronizer and registered outputs
    always_ff @(posedge CPUCLK) begin
        if (RESET) begin
            r_state        <= c_st_idle;
            r_cnt          <= '0;
            r_to_cnt       <= '0;
            r_rw_q         <= 1'b0;
            r_as_seen_high <= 1'b0;
            r_iordy_m      <= 1'b1;
            r_iordy_s      <= 1'b1;
            IDERD_n        <= 1'b1;
            IDEWR_n        <= 1'b1;
            IDEBUF_n       <= 1'b1;
            DTACK_n        <= 1'b1;
            DTACK_OE       <= 1'b0;
            BERR_n         <= 1'b1;
            BUSY           <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_to_cnt       <= w_to_nxt;
            r_rw_q         <= w_rw_nxt;
            r_as_seen_high <= w_seen_nxt;
            r_iordy_m      <= IORDY;
            r_iordy_s      <= r_iordy_m;
            IDERD_n        <= w_iderd_n;
            IDEWR_n        <= w_idewr_n;
            IDEBUF_n       <= w_idebuf_n;
            DTACK_n        <= w_dtack_n;
            DTACK_OE       <= w_dtack_oe;
            BERR_n         <= w_berr_n;
            BUSY           <= w_busy;
        end
    end

    // Next-state logic; AS_n high in any active phase aborts into RECOVER
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_to_nxt    = r_to_cnt;
        w_rw_nxt    = r_rw_q;
        w_seen_nxt  = r_as_seen_high;
        case (r_state)
            c_st_idle: begin
                if (AS_n) begin
                    w_seen_nxt = 1'b1;
                end
                if (!IDECS_n && !AS_n && !UDS_n && r_as_seen_high) begin
                    w_state_nxt = c_st_setup;
                    w_cnt_nxt   = c_setup_ld;
                    w_rw_nxt    = RW;
                    w_seen_nxt  = 1'b0;
                end
            end
            c_st_setup: begin
                if (AS_n) begin
                    w_state_nxt = c_st_recover;
                    w_cnt_nxt   = c_recover_ld;
                end else if (r_cnt == '0) begin
                    w_state_nxt = c_st_strobe;
                    w_cnt_nxt   = c_pulse_ld;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            c_st_strobe: begin
                if (AS_n) begin
                    w_state_nxt = c_st_recover;
                    w_cnt_nxt   = c_recover_ld;
                end else if (r_cnt == '0) begin
                    if (r_iordy_s) begin
                        w_state_nxt = r_rw_q ? c_st_ack : c_st_hold;
                        w_cnt_nxt   = c_hold_ld;
                    end else begin
                        w_state_nxt = c_st_waitrdy;
                        w_to_nxt    = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            c_st_waitrdy: begin
                if (AS_n) begin
                    w_state_nxt = c_st_recover;
                    w_cnt_nxt   = c_recover_ld;
                end else if (r_iordy_s) begin
                    w_state_nxt = r_rw_q ? c_st_ack : c_st_hold;
                    w_cnt_nxt   = c_hold_ld;
                end else if (r_to_cnt == c_to_last) begin
                    w_state_nxt = c_st_err;
                end else begin
                    w_to_nxt = r_to_cnt + 1'b1;
                end
            end
            c_st_hold: begin
                if (AS_n) begin
                    w_state_nxt = c_st_recover;
                    w_cnt_nxt   = c_recover_ld;
                end else if (r_cnt == '0) begin
                    w_state_nxt = c_st_ack;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            c_st_ack, c_st_err: begin
                if (AS_n) begin
                    w_state_nxt = c_st_recover;
                    w_cnt_nxt   = c_recover_ld;
                end
            end
            c_st_recover: begin
                if (AS_n) begin
                    w_seen_nxt = 1'b1;
                end
                if (r_cnt == '0) begin
                    w_state_nxt = c_st_idle;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Moore decode of the state being entered, so outputs register with it
    always_comb begin
        w_iderd_n  = 1'b1;
        w_idewr_n  = 1'b1;
        w_idebuf_n = 1'b1;
        w_dtack_n  = 1'b1;
        w_dtack_oe = 1'b0;
        w_berr_n   = 1'b1;
        w_busy     = (w_state_nxt != c_st_idle);
        case (w_state_nxt)
            c_st_setup, c_st_hold: begin
                w_idebuf_n = 1'b0;
            end
            c_st_strobe, c_st_waitrdy: begin
                w_idebuf_n = 1'b0;
                w_iderd_n  = !w_rw_nxt;
                w_idewr_n  = w_rw_nxt;
            end
            c_st_ack: begin
                w_idebuf_n = 1'b0;
                w_dtack_n  = 1'b0;
                w_dtack_oe = 1'b1;
                w_iderd_n  = !w_rw_nxt;
            end
            c_st_err: begin
                w_berr_n = 1'b0;
            end
            default: begin
                w_idebuf_n = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/ide_pio_sequencer.md
# ide_pio_sequencer

Registered bus-cycle sequencer between the 68000 bus and the IDE drive. It sits directly downstream of the combinational IDE chip-select decode and consumes its active-low IDECS_n. It converts each decoded 16-bit CPU access into PIO-compliant IDE timing: address setup, strobe pulse, IORDY wait, write hold and recovery. It drives DTACK_n only when the drive transfer has completed, and raises BERR_n if IORDY never returns.

## Interface
Parameters:
- T_SETUP, 2: cycles from cycle accept (IDEBUF_n low) to strobe assert; ≥1.
- T_PULSE, 6: minimum strobe-low cycles before IORDY is examined; ≥1.
- T_HOLD, 1: write-only cycles between IDEWR_n deassert and DTACK_n assert; ≥1.
- T_RECOVER, 2: idle cycles after a cycle ends before a new one is accepted; ≥1.
- IORDY_TIMEOUT, 255: WAITRDY cycles before bus error; ≥1.
- CNT_W, 8: width of the phase and timeout counters. Every T_* and IORDY_TIMEOUT must be < 2^CNT_W.

Ports:
- CPUCLK  in  1  CPU clock; all state changes on rising edge.
- RESET  in  1  Synchronous, active-high reset.
- IDECS_n  in  1  Decoded IDE select from the chip-select decode, active low.
- AS_n  in  1  68000 address strobe.
- UDS_n  in  1  68000 upper data strobe; the block handles 16-bit accesses only.
- RW  in  1  1 = read, 0 = write.
- IORDY  in  1  Drive ready, asynchronous.
- IDERD_n  out  1  IDE read strobe.
- IDEWR_n  out  1  IDE write strobe.
- IDEBUF_n  out  1  Enable for the '245 data buffers, active low.
- DTACK_n  out  1  Data acknowledge level.
- DTACK_OE  out  1  Tri-state enable for DTACK_n at the pin.
- BERR_n  out  1  Bus error (open-drain at board level).
- BUSY  out  1  High in any state other than IDLE.

## Operation
- All outputs are registered Moore decodes of the state and are valid in the cycle the state is entered.
- Reset values: IDERD_n=1, IDEWR_n=1, IDEBUF_n=1, DTACK_n=1, DTACK_OE=0, BERR_n=1, BUSY=0, state=IDLE, counters=0.
- IORDY passes through a 2-flop synchronizer (iordy_s). Synchronizer flops reset to 1.
- States:
  - IDLE: accept when IDECS_n=0, AS_n=0 and UDS_n=0 at an edge. Latch RW into rw_q, load the counter with T_SETUP-1, go to SETUP.
  - SETUP: IDEBUF_n=0. When the counter reaches 0, load T_PULSE-1 and go to STROBE.
  - STROBE: IDEBUF_n=0; IDERD_n=0 if rw_q=1, else IDEWR_n=0. When the counter reaches 0:
    - iordy_s=1: go to ACK (read) or HOLD (write).
    - iordy_s=0: clear the timeout counter and go to WAITRDY.
  - WAITRDY: strobe and buffer remain asserted. The timeout counter increments each cycle.
    - iordy_s=1: go to ACK or HOLD as in STROBE.
    - Timeout counter = IORDY_TIMEOUT-1 with iordy_s=0: go to ERR.
  - HOLD (write only): IDEWR_n=1, IDEBUF_n=0. After T_HOLD cycles, go to ACK.
  - ACK: DTACK_n=0, DTACK_OE=1, IDEBUF_n=0. For reads, IDERD_n stays 0 so the drive holds data until the CPU latches it. On AS_n=1, load T_RECOVER-1 and go to RECOVER.
  - ERR: BERR_n=0, all strobes 1, IDEBUF_n=1. On AS_n=1, go to RECOVER.
  - RECOVER: all outputs inactive, BUSY=1. Requests are ignored. When the counter reaches 0, go to IDLE.
- Abort: AS_n=1 sampled in SETUP, STROBE, WAITRDY or HOLD sends the block to RECOVER. Strobes, buffer and DTACK are deasserted in the cycle RECOVER is entered.
- DTACK_OE=0 in every state except ACK, so the pin is released for other slaves.
- A request still asserted on leaving RECOVER is not re-accepted until AS_n has gone high and low again. Track this with an as_seen_high flag, set in RECOVER and IDLE when AS_n=1.
- RESET wins over everything, including mid-strobe: the next edge forces all reset values.

## Timing
- Accept edge is E0. IDEBUF_n falls after E0.
- Strobe falls after E(T_SETUP) and is held for at least T_PULSE cycles.
- Read with IORDY high: DTACK_n falls after E(T_SETUP+T_PULSE), i.e. E8 at default parameters.
- Write with IORDY high: IDEWR_n rises after E8 and DTACK_n falls after E(8+T_HOLD), i.e. E9.
- IORDY latency is 2 cycles. IORDY rising at edge k is seen as iordy_s at k+2, and the block exits WAITRDY after edge k+2.
- Minimum spacing between accepts is T_SETUP+T_PULSE+1+T_RECOVER cycles plus the AS_n-high time.

## Test plan
- Read, IORDY=1, default parameters:
  - IDEBUF_n=0 at E0+, IDERD_n=0 at E2+, DTACK_n=0 and DTACK_OE=1 at E8+.
  - AS_n raised at E10 → IDERD_n=1 and DTACK_OE=0 at E10+; BUSY=0 at E12+.
- Write, IORDY=1: IDEWR_n low for exactly cycles E2..E7. IDEWR_n=1 at E8+ with IDEBUF_n still 0. DTACK_n=0 at E9+.
- Read with IORDY held low until E20: IDERD_n stays 0 through E22. DTACK_n=0 at E22+.
- IORDY stuck low with IORDY_TIMEOUT=4: BERR_n=0 at E12+ with all strobes 1. BERR_n returns to 1 after AS_n rises.
- Abort: AS_n raised in STROBE at E4 → strobes 1 at E4+. DTACK_n is never asserted. IDLE after T_RECOVER cycles.
- RESET pulsed during WAITRDY: all outputs at reset values after that edge. A new request then completes normally; back-to-back requests honour RECOVER.
